// File: rtl/pipe_hazard_ctrl_if.sv
// =============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Brief    : Hazard inputs and stall/flush controls of pipe_hazard_ctrl.
//             Optional STALL_PERF_EN adds the stall performance counters.
//  Revision : 1.0
// =============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if;
    logic       MemReadEX;
    logic [4:0] rfile_wnEX;
    logic [4:0] rsID;
    logic [4:0] rtID;
    logic       useRtID;
    logic       branch_takenEX;
    logic       dmem_req;
    logic       dmem_ready;
    logic       dbg_halt;
    logic       dbg_step;

    logic       pc_en;
    logic       en_IFID;
    logic       en_IDEX;
    logic       en_EXMEM;
    logic       en_MEMWB;
    logic       flush_IFID;
    logic       flush_IDEX;
    logic       bubble_MEMWB;
    logic       halted;
    logic       mem_err;
    logic [2:0] state;
`ifdef STALL_PERF_EN
    logic [31:0] cnt_lu;
    logic [31:0] cnt_mem;
    logic [31:0] cnt_flush;
`endif

    // Controller side: consumes hazard status, drives the pipeline controls.
    modport master (
        input  MemReadEX, rfile_wnEX, rsID, rtID, useRtID, branch_takenEX,
        input  dmem_req, dmem_ready, dbg_halt, dbg_step,
        output pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
        output flush_IFID, flush_IDEX, bubble_MEMWB, halted, mem_err, state
`ifdef STALL_PERF_EN
        , output cnt_lu, cnt_mem, cnt_flush
`endif
    );

    // Datapath side.
    modport slave (
        output MemReadEX, rfile_wnEX, rsID, rtID, useRtID, branch_takenEX,
        output dmem_req, dmem_ready, dbg_halt, dbg_step,
        input  pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
        input  flush_IFID, flush_IDEX, bubble_MEMWB, halted, mem_err, state
`ifdef STALL_PERF_EN
        , input cnt_lu, cnt_mem, cnt_flush
`endif
    );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// =============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Stall/flush controller for the 5-stage pipeline (load-use,
//             branch flush, dmem wait with timeout, debug halt/step).
//             Optional macro STALL_PERF_EN adds saturating stall counters.
//  Revision : 1.0
// =============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_hazard_ctrl_if.master   hz
);

    localparam logic [2:0] c_RUN      = 3'd0;
    localparam logic [2:0] c_MEM_WAIT = 3'd1;
    localparam logic [2:0] c_HALTED   = 3'd2;
    localparam logic [2:0] c_STEP     = 3'd3;
    localparam logic [2:0] c_ERR      = 3'd4;

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(MEM_TIMEOUT);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_waitCnt;
    logic             r_memErr;
    logic             r_halted;

    logic [2:0]       w_stateNxt;
    logic [CNT_W-1:0] w_waitCntNxt;
    logic [CNT_W-1:0] w_waitCntInc;
    logic             w_memErrNxt;

    logic w_lu, w_ms, w_active;
    logic w_pcEn, w_enIfId, w_enIdEx, w_enExMem, w_enMemWb;
    logic w_flushIfId, w_flushIdEx, w_bubbleMemWb;

    assign w_lu = hz.MemReadEX && (hz.rfile_wnEX != 5'd0) &&
                  ((hz.rfile_wnEX == hz.rsID) ||
                   (hz.useRtID && (hz.rfile_wnEX == hz.rtID)));
    assign w_ms = hz.dmem_req && !hz.dmem_ready;

    assign w_active = (r_state == c_RUN) || (r_state == c_MEM_WAIT) ||
                      (r_state == c_STEP);

    assign w_waitCntInc = r_waitCnt + 1'b1;

    // Pipeline controls are combinational so a stall takes effect the same cycle.
    always_comb begin
        w_pcEn        = 1'b0;
        w_enIfId      = 1'b0;
        w_enIdEx      = 1'b0;
        w_enExMem     = 1'b0;
        w_enMemWb     = 1'b0;
        w_flushIfId   = 1'b0;
        w_flushIdEx   = 1'b0;
        w_bubbleMemWb = 1'b0;
        if (!reset) begin
            if (w_active) begin
                if (w_ms) begin
                    w_enMemWb     = 1'b1;
                    w_bubbleMemWb = 1'b1;
                end else if (hz.branch_takenEX) begin
                    w_pcEn      = 1'b1;
                    w_enIfId    = 1'b1;
                    w_enIdEx    = 1'b1;
                    w_enExMem   = 1'b1;
                    w_enMemWb   = 1'b1;
                    w_flushIfId = 1'b1;
                    w_flushIdEx = 1'b1;
                end else if (w_lu) begin
                    w_enIdEx    = 1'b1;
                    w_flushIdEx = 1'b1;
                    w_enExMem   = 1'b1;
                    w_enMemWb   = 1'b1;
                end else begin
                    w_pcEn    = 1'b1;
                    w_enIfId  = 1'b1;
                    w_enIdEx  = 1'b1;
                    w_enExMem = 1'b1;
                    w_enMemWb = 1'b1;
                end
            end else if (r_state == c_ERR) begin
                w_bubbleMemWb = 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNxt   = r_state;
        w_waitCntNxt = r_waitCnt;
        w_memErrNxt  = r_memErr;
        case (r_state)
            c_RUN: begin
                if (w_ms) begin
                    w_stateNxt   = c_MEM_WAIT;
                    w_waitCntNxt = {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (hz.dbg_halt) begin
                    w_stateNxt = c_HALTED;
                end
            end
            c_MEM_WAIT: begin
                // A halt request is only honoured once the access completes.
                if (hz.dmem_ready) begin
                    w_stateNxt   = hz.dbg_halt ? c_HALTED : c_RUN;
                    w_waitCntNxt = '0;
                end else begin
                    w_waitCntNxt = w_waitCntInc;
                    if (w_waitCntInc >= c_TIMEOUT) begin
                        w_stateNxt  = c_ERR;
                        w_memErrNxt = 1'b1;
                    end
                end
            end
            c_HALTED: begin
                if (hz.dbg_step) begin
                    w_stateNxt = c_STEP;
                end else if (!hz.dbg_halt) begin
                    w_stateNxt = c_RUN;
                end
            end
            c_STEP: begin
                if (w_ms) begin
                    w_stateNxt   = c_MEM_WAIT;
                    w_waitCntNxt = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    w_stateNxt = c_HALTED;
                end
            end
            c_ERR: begin
                w_stateNxt = c_ERR;
            end
            default: begin
                w_stateNxt = c_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_RUN;
            r_waitCnt <= '0;
            r_memErr  <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_stateNxt;
            r_waitCnt <= w_waitCntNxt;
            r_memErr  <= w_memErrNxt;
            r_halted  <= (w_stateNxt == c_HALTED);
        end
    end

    assign hz.pc_en        = w_pcEn;
    assign hz.en_IFID      = w_enIfId;
    assign hz.en_IDEX      = w_enIdEx;
    assign hz.en_EXMEM     = w_enExMem;
    assign hz.en_MEMWB     = w_enMemWb;
    assign hz.flush_IFID   = w_flushIfId;
    assign hz.flush_IDEX   = w_flushIdEx;
    assign hz.bubble_MEMWB = w_bubbleMemWb;
    assign hz.halted       = r_halted;
    assign hz.mem_err      = r_memErr;
    assign hz.state        = r_state;

`ifdef STALL_PERF_EN
    logic [31:0] r_cntLu;
    logic [31:0] r_cntMem;
    logic [31:0] r_cntFlush;
    logic        w_winLu, w_winMem, w_winFlush;

    // The winning cause is recovered from the control pattern it produced.
    assign w_winMem   = w_active && w_bubbleMemWb;
    assign w_winFlush = w_flushIfId;
    assign w_winLu    = w_flushIdEx && !w_flushIfId;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cntLu    <= '0;
            r_cntMem   <= '0;
            r_cntFlush <= '0;
        end else begin
            if (w_winLu && (r_cntLu != 32'hFFFF_FFFF))
                r_cntLu <= r_cntLu + 32'd1;
            if (w_winMem && (r_cntMem != 32'hFFFF_FFFF))
                r_cntMem <= r_cntMem + 32'd1;
            if (w_winFlush && (r_cntFlush != 32'hFFFF_FFFF))
                r_cntFlush <= r_cntFlush + 32'd1;
        end
    end

    assign hz.cnt_lu    = r_cntLu;
    assign hz.cnt_mem   = r_cntMem;
    assign hz.cnt_flush = r_cntFlush;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// =============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
//  Revision : 1.0
// =============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    localparam int S_RUN = 0, S_MW = 1, S_HALT = 2, S_STEP = 3, S_ERR = 4;

    // Control vector order: pc_en en_IFID en_IDEX en_EXMEM en_MEMWB flush_IFID flush_IDEX bubble_MEMWB
    localparam logic [7:0] V_ALL  = 8'b11111000;
    localparam logic [7:0] V_MS   = 8'b00001001;
    localparam logic [7:0] V_BR   = 8'b11111110;
    localparam logic [7:0] V_LU   = 8'b00111010;
    localparam logic [7:0] V_ERR  = 8'b00000001;
    localparam logic [7:0] V_NONE = 8'b00000000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hzIf ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hzIf)
    );

    logic [7:0] dutCtrl;
    assign dutCtrl = {hzIf.pc_en, hzIf.en_IFID, hzIf.en_IDEX, hzIf.en_EXMEM,
                      hzIf.en_MEMWB, hzIf.flush_IFID, hzIf.flush_IDEX, hzIf.bubble_MEMWB};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        hzIf.MemReadEX = 0; hzIf.rfile_wnEX = 0; hzIf.rsID = 0; hzIf.rtID = 0;
        hzIf.useRtID = 0; hzIf.branch_takenEX = 0; hzIf.dmem_req = 0;
        hzIf.dmem_ready = 0; hzIf.dbg_halt = 0; hzIf.dbg_step = 0;
    endtask

    task automatic doReset();
        reset = 1; setIdle(); tick(); reset = 0;
    endtask

    // ---------------- behavioural reference ----------------
    int mState, mWaited;
    bit mErr;
    longint mLu, mMem, mFl;

    function automatic bit isActive(int s);
        return s == S_RUN || s == S_MW || s == S_STEP;
    endfunction

    function automatic logic [7:0] modelCtrl();
        bit ms, lu;
        ms = hzIf.dmem_req && !hzIf.dmem_ready;
        lu = hzIf.MemReadEX && hzIf.rfile_wnEX != 0 &&
             (hzIf.rfile_wnEX == hzIf.rsID || (hzIf.useRtID && hzIf.rfile_wnEX == hzIf.rtID));
        if (reset)              return V_NONE;
        if (mState == S_ERR)    return V_ERR;
        if (!isActive(mState))  return V_NONE;
        if (ms)                 return V_MS;
        if (hzIf.branch_takenEX) return V_BR;
        if (lu)                 return V_LU;
        return V_ALL;
    endfunction

    task automatic modelAdvance();
        logic [7:0] c;
        bit ms;
        c  = modelCtrl();
        ms = hzIf.dmem_req && !hzIf.dmem_ready;
        if (reset) begin
            mState = S_RUN; mWaited = 0; mErr = 0; mLu = 0; mMem = 0; mFl = 0;
            return;
        end
        if (c == V_MS) mMem++;
        if (c == V_BR) mFl++;
        if (c == V_LU) mLu++;
        if (mState == S_RUN || mState == S_STEP) begin
            if (ms) begin mState = S_MW; mWaited = 1; end
            else if (mState == S_STEP) mState = S_HALT;
            else if (hzIf.dbg_halt) mState = S_HALT;
        end else if (mState == S_MW) begin
            if (hzIf.dmem_ready) begin
                mWaited = 0;
                mState = hzIf.dbg_halt ? S_HALT : S_RUN;
            end else begin
                mWaited++;
                if (mWaited >= TO) begin mState = S_ERR; mErr = 1; end
            end
        end else if (mState == S_HALT) begin
            if (hzIf.dbg_step) mState = S_STEP;
            else if (!hzIf.dbg_halt) mState = S_RUN;
        end
    endtask

    // ---------------- single-cycle vector table ----------------
    typedef struct {
        string      name;
        bit         memRead;
        logic [4:0] wn, rs, rt;
        bit         useRt, br;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"idle",        0, 5'd0, 5'd0, 5'd0, 0, 0, V_ALL};
        vecs[1] = '{"lu_rs",       1, 5'd5, 5'd5, 5'd9, 0, 0, V_LU};
        vecs[2] = '{"lu_rt",       1, 5'd7, 5'd3, 5'd7, 1, 0, V_LU};
        vecs[3] = '{"rt_unused",   1, 5'd7, 5'd3, 5'd7, 0, 0, V_ALL};
        vecs[4] = '{"wn_zero",     1, 5'd0, 5'd0, 5'd0, 1, 0, V_ALL};
        vecs[5] = '{"no_load",     0, 5'd5, 5'd5, 5'd5, 1, 0, V_ALL};
        vecs[6] = '{"branch",      0, 5'd1, 5'd2, 5'd3, 0, 1, V_BR};
        vecs[7] = '{"branch_lu",   1, 5'd5, 5'd5, 5'd0, 0, 1, V_BR};

        reset = 1; setIdle();
        #1;
        // Reset cycle: controls gated off even with a branch presented.
        hzIf.branch_takenEX = 1;
        @(posedge clk); #3;
        check("reset_ctrl", {24'd0, dutCtrl}, {24'd0, V_NONE});
        #1; tick();
        reset = 0; setIdle(); #2;
        check("reset_regs", {27'd0, hzIf.state, hzIf.halted, hzIf.mem_err}, 32'd0);
        tick();

        foreach (vecs[i]) begin
            hzIf.MemReadEX = vecs[i].memRead; hzIf.rfile_wnEX = vecs[i].wn;
            hzIf.rsID = vecs[i].rs; hzIf.rtID = vecs[i].rt;
            hzIf.useRtID = vecs[i].useRt; hzIf.branch_takenEX = vecs[i].br;
            #2;
            check(vecs[i].name, {24'd0, dutCtrl}, {24'd0, vecs[i].exp});
            tick();
        end

        // Memory wait: 3 stalled cycles, then ready.
        doReset();
        hzIf.dmem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("memwait_ctrl", {24'd0, dutCtrl}, {24'd0, V_MS});
            check("memwait_state", {29'd0, hzIf.state}, (i == 0) ? S_RUN : S_MW);
            tick();
        end
        hzIf.dmem_ready = 1; #2;
        check("memready_ctrl", {24'd0, dutCtrl}, {24'd0, V_ALL});
        tick(); setIdle(); #2;
        check("memready_state", {29'd0, hzIf.state}, S_RUN);
        tick();

        // Timeout: ERR after TO wait cycles, sticky until reset.
        hzIf.dmem_req = 1;
        for (int i = 0; i < TO; i++) tick();
        #2;
        check("timeout_state", {29'd0, hzIf.state}, S_ERR);
        check("timeout_err", {31'd0, hzIf.mem_err}, 32'd1);
        check("err_ctrl", {24'd0, dutCtrl}, {24'd0, V_ERR});
        hzIf.dmem_ready = 1; tick(); tick(); #2;
        check("err_sticky", {28'd0, hzIf.state, hzIf.mem_err}, {28'd0, 3'(S_ERR), 1'b1});
        reset = 1; #0.1;
        #1;
        check("err_reset_ctrl", {24'd0, dutCtrl}, {24'd0, V_NONE});
        tick(); reset = 0; setIdle(); #2;
        check("err_cleared", {28'd0, hzIf.state, hzIf.mem_err}, {28'd0, 3'(S_RUN), 1'b0});
        tick();

        // Debug: halt during a memory wait, then single step, then resume.
        hzIf.dbg_halt = 1; hzIf.dmem_req = 1;
        tick(); #2;
        check("halt_waits_state", {29'd0, hzIf.state}, S_MW);
        check("halt_waits_ctrl", {24'd0, dutCtrl}, {24'd0, V_MS});
        tick(); hzIf.dmem_ready = 1; #2;
        check("halt_ready_ctrl", {24'd0, dutCtrl}, {24'd0, V_ALL});
        tick(); hzIf.dmem_req = 0; hzIf.dmem_ready = 0; #2;
        check("halted_regs", {28'd0, hzIf.state, hzIf.halted}, {28'd0, 3'(S_HALT), 1'b1});
        check("halted_ctrl", {24'd0, dutCtrl}, {24'd0, V_NONE});
        tick(); hzIf.dbg_step = 1; tick(); hzIf.dbg_step = 0; #2;
        check("step_state", {28'd0, hzIf.state, hzIf.halted}, {28'd0, 3'(S_STEP), 1'b0});
        check("step_ctrl", {24'd0, dutCtrl}, {24'd0, V_ALL});
        tick(); #2;
        check("step_back", {24'd0, dutCtrl, hzIf.state}, {21'd0, V_NONE, 3'(S_HALT)});
        hzIf.dbg_halt = 0; tick(); #2;
        check("resume", {20'd0, dutCtrl, hzIf.state, hzIf.halted}, {20'd0, V_ALL, 3'(S_RUN), 1'b0});
        tick();

`ifdef STALL_PERF_EN
        doReset();
        hzIf.MemReadEX = 1; hzIf.rfile_wnEX = 5; hzIf.rsID = 5;
        tick(); tick(); setIdle();
        hzIf.dmem_req = 1;
        tick(); tick(); tick();
        hzIf.dmem_ready = 1; tick(); hzIf.dmem_ready = 0;
        tick(); tick();
        hzIf.dmem_ready = 1; tick(); setIdle();
        hzIf.branch_takenEX = 1; tick(); setIdle(); #2;
        check("perf_lu", hzIf.cnt_lu, 32'd2);
        check("perf_mem", hzIf.cnt_mem, 32'd5);
        check("perf_flush", hzIf.cnt_flush, 32'd1);
        tick();
`endif

        // Randomized run against the reference model.
        mState = S_RUN; mWaited = 0; mErr = 0; mLu = 0; mMem = 0; mFl = 0;
        doReset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            hzIf.MemReadEX = ($urandom_range(0, 2) == 0);
            hzIf.rfile_wnEX = 5'($urandom_range(0, 3));
            hzIf.rsID = 5'($urandom_range(0, 3));
            hzIf.rtID = 5'($urandom_range(0, 3));
            hzIf.useRtID = 1'($urandom_range(0, 1));
            hzIf.branch_takenEX = ($urandom_range(0, 5) == 0);
            hzIf.dmem_req = ($urandom_range(0, 2) == 0);
            hzIf.dmem_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) hzIf.dbg_halt = ~hzIf.dbg_halt;
            hzIf.dbg_step = ($urandom_range(0, 7) == 0);
            #2;
            check("rand_ctrl", {24'd0, dutCtrl}, {24'd0, modelCtrl()});
            check("rand_regs", {27'd0, hzIf.state, hzIf.halted, hzIf.mem_err},
                  {27'd0, 3'(mState), (mState == S_HALT), mErr});
            modelAdvance();
            tick();
        end
        reset = 0; setIdle(); #2;
`ifdef STALL_PERF_EN
        check("rand_cnt_lu", hzIf.cnt_lu, 32'(mLu));
        check("rand_cnt_mem", hzIf.cnt_mem, 32'(mMem));
        check("rand_cnt_flush", hzIf.cnt_flush, 32'(mFl));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
